// File: rtl/branch_resolver_if.sv
// Branch resolver bus: Fetch prediction, Decode/Execute pipeline control,
// Execute branch result and the predictor-update / redirect outputs.
// The statistics counters exist only when BRANCH_STATS_EN is defined.
interface branch_resolver_if #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 32
);
  logic             pc_src_pred_f_i;
  logic [IDX_W-1:0] pred_idx_f_i;
  logic             stall_d_i;
  logic             flush_d_i;
  logic             flush_e_i;
  logic             branch_e_i;
  logic             branch_taken_e_i;
  logic             pred_update_en_o;
  logic [IDX_W-1:0] pred_update_idx_o;
  logic             pc_src_res_e_o;
  logic             mispredict_e_o;
  logic             redirect_taken_o;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] mispredict_cnt_o;

  modport master (
    output pc_src_pred_f_i, pred_idx_f_i, stall_d_i, flush_d_i, flush_e_i,
           branch_e_i, branch_taken_e_i,
    input  pred_update_en_o, pred_update_idx_o, pc_src_res_e_o,
           mispredict_e_o, redirect_taken_o, branch_cnt_o, mispredict_cnt_o
  );
  modport slave (
    input  pc_src_pred_f_i, pred_idx_f_i, stall_d_i, flush_d_i, flush_e_i,
           branch_e_i, branch_taken_e_i,
    output pred_update_en_o, pred_update_idx_o, pc_src_res_e_o,
           mispredict_e_o, redirect_taken_o, branch_cnt_o, mispredict_cnt_o
  );
`else
  modport master (
    output pc_src_pred_f_i, pred_idx_f_i, stall_d_i, flush_d_i, flush_e_i,
           branch_e_i, branch_taken_e_i,
    input  pred_update_en_o, pred_update_idx_o, pc_src_res_e_o,
           mispredict_e_o, redirect_taken_o
  );
  modport slave (
    input  pc_src_pred_f_i, pred_idx_f_i, stall_d_i, flush_d_i, flush_e_i,
           branch_e_i, branch_taken_e_i,
    output pred_update_en_o, pred_update_idx_o, pc_src_res_e_o,
           mispredict_e_o, redirect_taken_o
  );
`endif
endinterface

// File: rtl/branch_resolver.sv
// Branch resolver: carries each Fetch-stage direction prediction and its
// predictor index through Decode and Execute, then compares it against the
// resolved direction in Execute to drive predictor update and redirect.
// All outputs are combinational from the Execute tracking register and the
// current Execute inputs.
// Optional feature: define BRANCH_STATS_EN for saturating resolved-branch
// and mispredict counters.
module branch_resolver #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 32
) (
  input logic              clk_i,
  input logic              reset_i,
  branch_resolver_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             pred;
    logic [IDX_W-1:0] idx;
  } track_t;

  track_t d_q, e_q;
  logic   upd_en;
  logic   mispred;

  if (IDX_W < 1 || CNT_W < 1) begin : g_bad_cfg
    $error("branch_resolver: IDX_W and CNT_W must be at least 1");
  end

  // Decode tracking: flush wins over stall, stall holds, otherwise load Fetch
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      d_q <= '0;
    end else if (bus.flush_d_i) begin
      d_q.valid <= 1'b0;
    end else if (!bus.stall_d_i) begin
      d_q <= '{valid: 1'b1, pred: bus.pc_src_pred_f_i, idx: bus.pred_idx_f_i};
    end
  end

  // Execute tracking: flush kills the slot, otherwise follow Decode (bubbles too)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      e_q <= '0;
    end else if (bus.flush_e_i) begin
      e_q.valid <= 1'b0;
    end else begin
      e_q <= d_q;
    end
  end

  // Resolution is only meaningful for a live slot holding a conditional branch
  assign upd_en  = e_q.valid & bus.branch_e_i;
  assign mispred = upd_en & (e_q.pred != bus.branch_taken_e_i);

  assign bus.pred_update_en_o  = upd_en;
  assign bus.pred_update_idx_o = e_q.idx;
  assign bus.pc_src_res_e_o    = bus.branch_taken_e_i;
  assign bus.mispredict_e_o    = mispred;
  assign bus.redirect_taken_o  = mispred & bus.branch_taken_e_i;

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  // Saturating statistics counters; they stick at all-ones rather than wrap
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (upd_en && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (mispred && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  assign bus.branch_cnt_o     = branch_cnt;
  assign bus.mispredict_cnt_o = mispredict_cnt;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver. The stimulus process drives one
// vector per cycle and queues the hand-computed expected outputs; a
// monitor pops and compares them on the falling edge of the same cycle.
module tb_branch_resolver;
  localparam int IDX_W = 10;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  branch_resolver #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic             chk_idx;
    logic             en;
    logic [IDX_W-1:0] idx;
    logic             mis;
    logic             red;
    logic             res;
    logic             chk_cnt;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, got, want);
    end
  endtask

  // Monitor: outputs are combinational, so check mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp(nm, "update_en", 32'(bus.pred_update_en_o), 32'(e.en));
      cmp(nm, "mispredict", 32'(bus.mispredict_e_o), 32'(e.mis));
      cmp(nm, "redirect_taken", 32'(bus.redirect_taken_o), 32'(e.red));
      cmp(nm, "pc_src_res", 32'(bus.pc_src_res_e_o), 32'(e.res));
      if (e.chk_idx)
        cmp(nm, "update_idx", 32'(bus.pred_update_idx_o), 32'(e.idx));
`ifdef BRANCH_STATS_EN
      if (e.chk_cnt) begin
        cmp(nm, "branch_cnt", 32'(bus.branch_cnt_o), 32'(e.bc));
        cmp(nm, "mispredict_cnt", 32'(bus.mispredict_cnt_o), 32'(e.mc));
      end
`endif
    end
  end

  // One cycle of stimulus; expected outputs refer to this same cycle
  task automatic step(input logic pred, input logic [IDX_W-1:0] idx,
                      input logic stall, input logic fd, input logic fe,
                      input logic br, input logic tk, input logic r,
                      input logic chk, input logic ci, input logic en,
                      input logic [IDX_W-1:0] eidx, input logic mis,
                      input logic red, input string nm,
                      input logic cc = 1'b0, input int cnt = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.pc_src_pred_f_i  = pred;
    bus.pred_idx_f_i     = idx;
    bus.stall_d_i        = stall;
    bus.flush_d_i        = fd;
    bus.flush_e_i        = fe;
    bus.branch_e_i       = br;
    bus.branch_taken_e_i = tk;
    if (chk) begin
      e = '{chk_idx: ci, en: en, idx: eidx, mis: mis, red: red, res: tk,
            chk_cnt: cc, bc: CNT_W'(cnt), mc: CNT_W'(cnt)};
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  initial begin
    bus.pc_src_pred_f_i  = 1'b0;
    bus.pred_idx_f_i     = '0;
    bus.stall_d_i        = 1'b0;
    bus.flush_d_i        = 1'b0;
    bus.flush_e_i        = 1'b0;
    bus.branch_e_i       = 1'b0;
    bus.branch_taken_e_i = 1'b0;

    //   pred idx     stl fd fe br tk rst chk ci en idx    mis red
    step(0, 10'h000, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10'h000, 0, 0, "rst0");
    step(0, 10'h000, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10'h000, 0, 0, "rst1");
    // first Fetch prediction goes in while E still holds the reset slot
    step(1, 10'h005, 0, 0, 0, 1, 1, 0,  1, 1, 0, 10'h000, 0, 0, "reset_state");
    step(0, 10'h3FF, 0, 0, 0, 0, 0, 0,  1, 1, 0, 10'h000, 0, 0, "reset_bubble");
    step(1, 10'h011, 0, 0, 0, 1, 1, 0,  1, 1, 1, 10'h005, 0, 0, "correct_taken");
    step(1, 10'h00A, 0, 0, 0, 1, 1, 0,  1, 1, 1, 10'h3FF, 1, 1, "mis_taken");
    // Decode held for 3 cycles with Execute flushed; Fetch index keeps moving
    step(0, 10'h00B, 1, 0, 1, 1, 0, 0,  1, 1, 1, 10'h011, 1, 0, "mis_not_taken");
    step(0, 10'h00C, 1, 0, 1, 1, 1, 0,  1, 0, 0, 10'h000, 0, 0, "stall_e_dead0");
    step(0, 10'h00D, 1, 0, 1, 1, 1, 0,  1, 0, 0, 10'h000, 0, 0, "stall_e_dead1");
    step(0, 10'h020, 0, 0, 0, 1, 1, 0,  1, 0, 0, 10'h000, 0, 0, "stall_e_dead2");
    // held slot reaches E once, then stall+flush on Decode in the same cycle
    step(1, 10'h030, 1, 1, 0, 1, 1, 0,  1, 1, 1, 10'h00A, 0, 0, "stall_release");
    step(0, 10'h040, 0, 0, 0, 1, 0, 0,  1, 1, 1, 10'h020, 0, 0, "after_release");
    step(1, 10'h050, 0, 0, 0, 1, 1, 0,  1, 0, 0, 10'h000, 0, 0, "flush_over_stall");
    step(1, 10'h060, 0, 0, 0, 0, 1, 0,  1, 1, 0, 10'h040, 0, 0, "not_branch");
    // reset while predictions sit in D (0x60) and E (0x50)
    step(1, 10'h070, 0, 0, 0, 1, 0, 1,  1, 1, 1, 10'h050, 1, 0, "pre_reset");
    step(1, 10'h080, 0, 0, 0, 1, 0, 0,  1, 1, 0, 10'h000, 0, 0, "reset_drop0");
    step(0, 10'h090, 0, 0, 0, 1, 0, 0,  1, 1, 0, 10'h000, 0, 0, "reset_drop1");
    step(0, 10'h000, 0, 0, 0, 1, 1, 0,  1, 1, 1, 10'h080, 0, 0, "post_reset");

`ifdef BRANCH_STATS_EN
    // fresh counters, then 17 consecutive mispredicting branches
    step(0, 10'h000, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10'h000, 0, 0, "stats_rst");
    for (int k = 0; k < 20; k++) begin
      automatic logic live  = (k >= 2) && (k < 19);
      automatic int   cnt   = (k < 2) ? 0 : ((k - 2 > 15) ? 15 : k - 2);
      automatic logic cc    = (k == 0) || (k == 10) || (k >= 17);
      automatic logic [IDX_W-1:0] ei = (k < 2) ? '0 : IDX_W'(k - 2);
      step(0, IDX_W'(k), 0, 0, 0, (k < 19), 1, 0, 1, 1, live, ei, live, live,
           $sformatf("stats_%0d", k), cc, cnt);
    end
`endif

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
